twiddle_butterfly: RTL and testbench
====================================

# twiddle_butterfly

Radix-2 butterfly stage that consumes the four 6-bit twiddle codes produced by the twiddle lookup and applies them to four lanes of sample pairs. For each lane it computes a ± (b·w) using one shared serial shift-add multiplier. It sits directly downstream of the twiddle lookup and drives that block's enable to refresh the codes before each new job. Input and output use valid/ready handshakes.

## Interface
Parameters:
- DW, 8, sample width (signed two's complement)
- TW, 6, twiddle code width
- TFRAC, 3, twiddle fractional bits; twiddle value = code / 2^TFRAC (Q2.3)
- OW, 12, output width = DW + TW − TFRAC + 1

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- tw_en  out  1  enable to the twiddle lookup; high one cycle per job
- tw0..tw3  in  TW each  signed twiddle codes, sampled at input handshake
- in_valid  in  1  a_bus/b_bus valid
- in_ready  out  1  block can accept a job
- a_bus  in  4·DW  lane k at [k·DW +: DW], signed
- b_bus  in  4·DW  lane k at [k·DW +: DW], signed
- out_valid  out  1  results valid
- out_ready  in  1  consumer accepts results
- y_top  out  4·OW  lane k = a_k + p_k
- y_bot  out  4·OW  lane k = a_k − p_k

## Operation
FSM states: FETCH, IDLE, MUL, BFLY, DONE.
- Reset: state = FETCH. All outputs are 0: tw_en, in_ready, out_valid, y_top, y_bot. Lane counter and bit counter are 0.
- FETCH → IDLE unconditionally. On this edge, tw_en and in_ready are set to 1.
- IDLE: tw_en falls after its first IDLE cycle. in_ready stays at 1. When in_valid and in_ready are both high, latch a_bus, b_bus and tw0..tw3, set in_ready to 0 and lane = 0, then go to MUL.
- MUL: runs 6 cycles per lane, processing twiddle bit i = 0..5, LSB first.
  - If bit i is set, add b·2^i to a 14-bit accumulator.
  - Bit 5 has weight −2^5, so it is subtracted.
  - The result is the exact 14-bit signed product. After i = 5, go to BFLY.
- BFLY: runs 1 cycle.
  - p = product >>> TFRAC (arithmetic shift, floor), 11 bits.
  - a is sign-extended to OW bits.
  - Write y_top lane = a + p and y_bot lane = a − p.
  - No saturation is needed; the worst-case magnitude is 640.
  - Clear the accumulator. If lane < 3, increment lane and go to MUL; otherwise go to DONE and set out_valid to 1.
- DONE: y_top, y_bot and out_valid hold stable until out_valid and out_ready are both high. On that handshake, out_valid goes to 0 and the FSM goes to FETCH.
- Not-yet-written lanes of y_top/y_bot keep their previous values. They are only meaningful while out_valid = 1.
- in_valid while busy is ignored. Inputs are not sampled outside an IDLE handshake.
- Reset during any state aborts the job. Outputs return to their reset values on the first clock edge with rst_n low.

## Timing
- Input handshake at edge E0. Lane k uses MUL edges E0+7k+1 … E0+7k+6 and its BFLY edge is E0+7k+7.
- out_valid rises at edge E0+28, giving a latency of 28 cycles.
- Output handshake at edge H → FETCH. At H+1, in_ready = 1 and tw_en = 1. At H+2, tw_en = 0.
- Minimum job period: 31 cycles.
- in_ready and out_valid are never both 1.
- tw_en rising edge occurs at least one clock before any possible input handshake, so the twiddle codes have settled when they are sampled.

## Structure
- Package pim_fft_pkg holds:
  - constants DW, TW, TFRAC and OW;
  - the state enum {FETCH, IDLE, MUL, BFLY, DONE};
  - the lane-count constant 4.
- Sub-module shift_add_mul holds the 6-cycle serial signed multiplier. Its interface is: start, b, w, done, product[13:0].
- The top level holds the FSM, lane mux, input/output registers and butterfly add/sub.

## Test plan
- Positive twiddle: a0 = 10, b0 = 8, tw0 = 6'b001101 (13). Product = 104, p = 13. Expect y_top0 = 23, y_bot0 = −3.
- Extreme negative twiddle: a1 = 127, b1 = −128, tw1 = 6'b100011 (−29). Product = 3712, p = 464. Expect y_top1 = 591, y_bot1 = −337.
- Floor rounding: a2 = 0, b2 = 1, tw2 = 6'b101101 (−19). p = −3. Expect y_top2 = −3, y_bot2 = 3.
- Zero twiddle: tw3 = 0, a3 = −50, b3 = 99. Expect y_top3 = y_bot3 = −50. Also check out_valid rises exactly 28 cycles after the input handshake.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid rises. Expect outputs stable and in_ready = 0 throughout. Then assert out_ready: expect tw_en to pulse once and in_ready = 1 one cycle after the handshake.
- Mid-job reset: assert rst_n = 0 at cycle E0+10. Expect all outputs at 0 on the next edge. After release, expect FETCH → IDLE, and the following job to produce correct results.

Source files
------------

// File: rtl/pim_fft_pkg.sv
// rtl/pim_fft_pkg.sv - shared constants and FSM state type for the twiddle butterfly
package pim_fft_pkg;

    localparam int DW    = 8;                  // sample width, signed
    localparam int TW    = 6;                  // twiddle code width, signed Q2.3
    localparam int TFRAC = 3;                  // twiddle fractional bits
    localparam int OW    = DW + TW - TFRAC + 1; // butterfly output width
    localparam int PW    = DW + TW;            // exact product width
    localparam int LANES = 4;                  // sample pairs per job

    typedef enum logic [2:0] {
        FETCH,
        IDLE,
        MUL,
        BFLY,
        DONE
    } state_t;

endpackage

// File: rtl/twiddle_butterfly_if.sv
// rtl/twiddle_butterfly_if.sv - job/result handshake bundle between producer, butterfly and consumer
interface twiddle_butterfly_if;
    import pim_fft_pkg::*;

    logic                  tw_en;
    logic [TW-1:0]         tw0;
    logic [TW-1:0]         tw1;
    logic [TW-1:0]         tw2;
    logic [TW-1:0]         tw3;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   a_bus;
    logic [LANES*DW-1:0]   b_bus;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*OW-1:0]   y_top;
    logic [LANES*OW-1:0]   y_bot;

    modport master (
        input  tw_en, in_ready, out_valid, y_top, y_bot,
        output tw0, tw1, tw2, tw3, in_valid, a_bus, b_bus, out_ready
    );

    modport slave (
        output tw_en, in_ready, out_valid, y_top, y_bot,
        input  tw0, tw1, tw2, tw3, in_valid, a_bus, b_bus, out_ready
    );

endinterface

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - 6-cycle serial signed shift-add multiplier, LSB of twiddle first
module shift_add_mul
    import pim_fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] b,
    input  logic [TW-1:0]        w,
    output logic                 done,
    output logic signed [PW-1:0] product
);

    logic [2:0]          r_bit;
    logic signed [PW-1:0] r_acc;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_term;
    logic                 w_last;

    assign w_b_ext = {{(PW-DW){b[DW-1]}}, b};
    assign w_term  = w_b_ext <<< r_bit;
    assign w_last  = (r_bit == 3'(TW-1));
    assign done    = start && w_last;
    assign product = r_acc;

    // accumulate one partial product per cycle while running; the MSB of the
    // two's complement twiddle carries negative weight, so it is subtracted.
    // Any idle cycle clears the accumulator and bit counter for the next lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit <= '0;
            r_acc <= '0;
        end else if (start) begin
            if (w[r_bit]) begin
                r_acc <= w_last ? (r_acc - w_term) : (r_acc + w_term);
            end
            r_bit <= w_last ? 3'd0 : (r_bit + 3'd1);
        end else begin
            r_bit <= '0;
            r_acc <= '0;
        end
    end

endmodule

// File: rtl/twiddle_butterfly.sv
// rtl/twiddle_butterfly.sv - four-lane radix-2 butterfly a +/- b*w sharing one serial multiplier
module twiddle_butterfly
    import pim_fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    twiddle_butterfly_if.slave  bus
);

    state_t r_state;
    state_t w_state_nxt;

    logic r_tw_en,     w_tw_en_nxt;
    logic r_in_ready,  w_in_ready_nxt;
    logic r_out_valid, w_out_valid_nxt;

    logic [1:0]            r_lane;
    logic signed [DW-1:0]  r_a [LANES];
    logic signed [DW-1:0]  r_b [LANES];
    logic [TW-1:0]         r_w [LANES];
    logic [LANES*OW-1:0]   r_y_top;
    logic [LANES*OW-1:0]   r_y_bot;

    logic                   w_hs_in;
    logic                   w_mul_start;
    logic                   w_mul_done;
    logic signed [PW-1:0]   w_product;
    logic signed [PW-1:0]   w_prod_sh;
    logic signed [PW-TFRAC-1:0] w_p;
    logic signed [OW-1:0]   w_p_ext;
    logic signed [OW-1:0]   w_a_ext;
    logic signed [OW-1:0]   w_sum;
    logic signed [OW-1:0]   w_dif;

    assign w_hs_in     = (r_state == IDLE) && bus.in_valid && r_in_ready;
    assign w_mul_start = (r_state == MUL);

    shift_add_mul u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .b       (r_b[r_lane]),
        .w       (r_w[r_lane]),
        .done    (w_mul_done),
        .product (w_product)
    );

    // scale the exact product back to sample units (floor) and form both legs
    assign w_prod_sh = w_product >>> TFRAC;
    assign w_p       = w_prod_sh[PW-TFRAC-1:0];
    assign w_p_ext   = {{(OW-(PW-TFRAC)){w_p[PW-TFRAC-1]}}, w_p};
    assign w_a_ext   = {{(OW-DW){r_a[r_lane][DW-1]}}, r_a[r_lane]};
    assign w_sum     = w_a_ext + w_p_ext;
    assign w_dif     = w_a_ext - w_p_ext;

    assign bus.tw_en     = r_tw_en;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y_top     = r_y_top;
    assign bus.y_bot     = r_y_bot;

    // state register and registered handshake flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_tw_en     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tw_en     <= w_tw_en_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // next-state and next-flag decode; tw_en pulses on entry to IDLE so the
    // lookup refreshes its codes a cycle before any job can be accepted
    always_comb begin
        w_state_nxt     = r_state;
        w_tw_en_nxt     = r_tw_en;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            FETCH: begin
                w_state_nxt    = IDLE;
                w_tw_en_nxt    = 1'b1;
                w_in_ready_nxt = 1'b1;
            end
            IDLE: begin
                w_tw_en_nxt = 1'b0;
                if (w_hs_in) begin
                    w_in_ready_nxt = 1'b0;
                    w_state_nxt    = MUL;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_state_nxt = BFLY;
                end
            end
            BFLY: begin
                if (r_lane == 2'(LANES-1)) begin
                    w_state_nxt     = DONE;
                    w_out_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = MUL;
                end
            end
            DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // job capture on input handshake, lane stepping and result write-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane  <= '0;
            r_y_top <= '0;
            r_y_bot <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_w[k] <= '0;
            end
        end else begin
            if (w_hs_in) begin
                r_lane <= '0;
                for (int k = 0; k < LANES; k++) begin
                    r_a[k] <= bus.a_bus[k*DW +: DW];
                    r_b[k] <= bus.b_bus[k*DW +: DW];
                end
                r_w[0] <= bus.tw0;
                r_w[1] <= bus.tw1;
                r_w[2] <= bus.tw2;
                r_w[3] <= bus.tw3;
            end
            if (r_state == BFLY) begin
                r_y_top[r_lane*OW +: OW] <= w_sum;
                r_y_bot[r_lane*OW +: OW] <= w_dif;
                if (r_lane != 2'(LANES-1)) begin
                    r_lane <= r_lane + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_twiddle_butterfly.sv
// tb/tb_twiddle_butterfly.sv - directed self-checking bench for twiddle_butterfly
module tb_twiddle_butterfly;
    import pim_fft_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    twiddle_butterfly_if tif();

    twiddle_butterfly dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int va [4];
    int vb [4];
    int vw [4];
    int exp_top [4];
    int exp_bot [4];
    int lat;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_top%0d", tag, k), $signed(tif.y_top[k*OW +: OW]), exp_top[k]);
            chk($sformatf("%s_bot%0d", tag, k), $signed(tif.y_bot[k*OW +: OW]), exp_bot[k]);
        end
    endtask

    task automatic drive_vectors();
        for (int k = 0; k < 4; k++) begin
            tif.a_bus[k*DW +: DW] = va[k][DW-1:0];
            tif.b_bus[k*DW +: DW] = vb[k][DW-1:0];
        end
        tif.tw0 = vw[0][TW-1:0];
        tif.tw1 = vw[1][TW-1:0];
        tif.tw2 = vw[2][TW-1:0];
        tif.tw3 = vw[3][TW-1:0];
    endtask

    task automatic scramble_inputs();
        tif.a_bus = '1;
        tif.b_bus = '1;
        tif.tw0   = '1;
        tif.tw1   = 6'b010101;
        tif.tw2   = '1;
        tif.tw3   = 6'b011111;
    endtask

    // called at a negedge with in_ready high; returns edges from handshake to out_valid
    task automatic run_job(input string tag, output int latency);
        chk({tag, "_ready_before"}, tif.in_ready, 1);
        drive_vectors();
        tif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tif.in_valid = 1'b0;
        scramble_inputs();
        chk({tag, "_ready_after"}, tif.in_ready, 0);
        latency = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            latency++;
            @(negedge clk);
            if (tif.out_valid) break;
        end
    endtask

    task automatic chk_flags(input string tag, input int tw_en, input int in_ready, input int out_valid);
        chk({tag, "_tw_en"}, tif.tw_en, tw_en);
        chk({tag, "_in_ready"}, tif.in_ready, in_ready);
        chk({tag, "_out_valid"}, tif.out_valid, out_valid);
    endtask

    initial begin
        tif.in_valid  = 1'b0;
        tif.out_ready = 1'b0;
        tif.a_bus     = '0;
        tif.b_bus     = '0;
        tif.tw0       = '0;
        tif.tw1       = '0;
        tif.tw2       = '0;
        tif.tw3       = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_flags("rst", 0, 0, 0);
        exp_top = '{0, 0, 0, 0};
        exp_bot = '{0, 0, 0, 0};
        chk_lanes("rst");

        // FETCH -> IDLE, tw_en single pulse
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_flags("fetch1", 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        chk_flags("idle1", 0, 1, 0);

        // job 1: positive, extreme negative, floor rounding, zero twiddle
        va = '{10, 127, 0, -50};
        vb = '{8, -128, 1, 99};
        vw = '{13, -29, -19, 0};
        exp_top = '{23, 591, -3, -50};
        exp_bot = '{-3, -337, 3, -50};
        run_job("job1", lat);
        chk("job1_latency", lat, 28);
        chk_flags("job1_done", 0, 0, 1);
        chk_lanes("job1");

        // backpressure: results and flags hold for 10 cycles
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk_flags($sformatf("bp%0d", c), 0, 0, 1);
            chk_lanes($sformatf("bp%0d", c));
        end

        // output handshake, then tw_en pulses once and in_ready returns
        tif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tif.out_ready = 1'b0;
        chk_flags("hs_h0", 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_flags("hs_h1", 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        chk_flags("hs_h2", 0, 1, 0);

        // job 2 aborted by reset at E0+10; lane 0 already written at E0+7
        va = '{-128, 5, -1, 100};
        vb = '{-128, 7, -3, -100};
        vw = '{-32, 31, 9, 1};
        chk("job2_ready_before", tif.in_ready, 1);
        drive_vectors();
        tif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tif.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("job2_lane0_top_early", $signed(tif.y_top[0 +: OW]), 384);
        chk("job2_lane0_bot_early", $signed(tif.y_bot[0 +: OW]), -640);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_flags("midrst", 0, 0, 0);
        exp_top = '{0, 0, 0, 0};
        exp_bot = '{0, 0, 0, 0};
        chk_lanes("midrst");

        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_flags("fetch2", 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        chk_flags("idle2", 0, 1, 0);

        // job 3 after reset: full-scale product, positive, floor on negatives
        exp_top = '{384, 32, -5, 87};
        exp_bot = '{-640, -22, 3, 113};
        run_job("job3", lat);
        chk("job3_latency", lat, 28);
        chk_lanes("job3");
        tif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tif.out_ready = 1'b0;
        chk_flags("job3_hs", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
